// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit_if
//  Description : PC / instruction bus between the control FSM plus instruction
//                memory (master side) and the instruction fetch unit (slave
//                side).
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_fetch_unit_if;
  logic        fetch_start;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [31:0] branch_offset;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fault;

  // Control FSM and instruction memory drive requests and the fetched word.
  modport master (
    output fetch_start, pc_write, pc_src, branch_offset, inst_in,
    input  pc_out, ir, ir_valid, pc_plus4, busy, fault
  );

  // Fetch unit owns the PC and the instruction register.
  modport slave (
    input  fetch_start, pc_write, pc_src, branch_offset, inst_in,
    output pc_out, ir, ir_valid, pc_plus4, busy, fault
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Multicycle-CPU instruction fetch unit. Owns the PC, presents
//                it to instruction memory for one settle cycle (ADDR), then
//                captures the returned word into IR (LATCH). Misaligned
//                fetches load NOP_WORD and set a sticky fault flag.
//                Optional macro IFU_RANGE_CHECK_EN: also fault any fetch
//                outside the 64-word instruction memory (pc[31:8] != 0).
//  Revision    : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd100,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] ir_q;
  logic [31:0] pc_plus4_q;
  logic        ir_valid_q;
  logic        fault_q;

  logic [31:0] next_pc;
  logic        fetch_bad;

  // Next-PC candidate for a pc_write; relative to the last fetch, not the PC.
  always_comb begin
    next_pc = pc;
    case (bus.pc_src)
      2'b00:   next_pc = pc_plus4_q;
      2'b01:   next_pc = pc_plus4_q + (bus.branch_offset << 2);
      2'b10:   next_pc = {pc_plus4_q[31:28], ir_q[25:0], 2'b00};
      default: next_pc = pc;
    endcase
  end

  // PC cannot change outside IDLE, so checking it during LATCH is the same
  // as checking the address presented in ADDR.
  always_comb begin
`ifdef IFU_RANGE_CHECK_EN
    fetch_bad = (pc[1:0] != 2'b00) || (pc[31:8] != 24'd0);
`else
    fetch_bad = (pc[1:0] != 2'b00);
`endif
  end

  // Fetch sequencer, PC update and IR capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A simultaneous pc_write and fetch_start fetch from the new PC.
          if (bus.pc_write) begin
            pc         <= next_pc;
            ir_valid_q <= 1'b0;
          end
          if (bus.fetch_start) begin
            state      <= S_ADDR;
            ir_valid_q <= 1'b0;
          end
        end
        S_ADDR: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          ir_q       <= fetch_bad ? NOP_WORD : bus.inst_in;
          pc_plus4_q <= pc + 32'd4;
          ir_valid_q <= 1'b1;
          if (fetch_bad) begin
            fault_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_out   = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.pc_plus4 = pc_plus4_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. A transaction-level
//                reference model (PC update / whole fetch) predicts the
//                architectural state after each operation. A second instance
//                with a misaligned reset PC exercises the fault path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP1 = 32'h0000_0000;
  localparam logic [31:0] NOP2 = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [64];
  logic [31:0] noise;

  int checks   = 0;
  int failures = 0;

  inst_fetch_unit_if bus ();
  inst_fetch_unit_if bus2 ();

  inst_fetch_unit #(.RESET_PC(32'd100), .NOP_WORD(NOP1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  inst_fetch_unit #(.RESET_PC(32'd102), .NOP_WORD(NOP2)) dut_mis (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Instruction memory: 64 words, address wraps on pc[7:2].
  assign bus.inst_in  = mem[bus.pc_out[7:2]] ^ noise;
  assign bus2.inst_in = mem[bus2.pc_out[7:2]];

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc, m_ir, m_pp4;
  logic        m_v, m_fault;

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef IFU_RANGE_CHECK_EN
    return (a % 4 != 0) || (a >= 32'd256);
`else
    return (a % 4 != 0);
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'd100; m_ir = 32'd0; m_pp4 = 32'd0; m_v = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_update(input logic [1:0] src, input logic [31:0] off);
    m_v = 1'b0;
    if (src == 2'd0)      m_pc = m_pp4;
    else if (src == 2'd1) m_pc = m_pp4 + off * 32'd4;
    else if (src == 2'd2) m_pc = (m_pp4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
  endtask

  task automatic model_fetch();
    bit b;
    b = bad_addr(m_pc);
    m_ir    = b ? NOP1 : mem[(m_pc / 4) % 64];
    m_pp4   = m_pc + 32'd4;
    m_v     = 1'b1;
    m_fault = m_fault | b;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},       bus.pc_out,          m_pc);
    chk({tag, ".ir"},       bus.ir,              m_ir);
    chk({tag, ".ir_valid"}, 32'(bus.ir_valid),   32'(m_v));
    chk({tag, ".pc_plus4"}, bus.pc_plus4,        m_pp4);
    chk({tag, ".busy"},     32'(bus.busy),       32'd0);
    chk({tag, ".fault"},    32'(bus.fault),      32'(m_fault));
  endtask

  // One operation on the main instance; returns with the unit back in IDLE.
  task automatic run_op(input bit fs, input bit pw, input logic [1:0] src,
                        input logic [31:0] off, input bit stray);
    @(negedge clk);
    bus.fetch_start = fs; bus.pc_write = pw; bus.pc_src = src; bus.branch_offset = off;
    @(negedge clk);
    bus.fetch_start = 1'b0; bus.pc_write = 1'b0;
    if (pw) model_update(src, off);
    if (fs) begin
      model_fetch();
      chk("busy_in_addr", 32'(bus.busy), 32'd1);
      noise = $urandom | 32'd1;            // must not be captured in ADDR
      if (stray) begin
        bus.fetch_start = 1'b1; bus.pc_write = 1'b1;
        bus.pc_src = 2'($urandom_range(0, 3)); bus.branch_offset = $urandom;
      end
      @(negedge clk);
      noise = 32'd0;
      bus.fetch_start = 1'b0; bus.pc_write = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic op2(input bit fs, input bit pw, input logic [1:0] src);
    @(negedge clk);
    bus2.fetch_start = fs; bus2.pc_write = pw; bus2.pc_src = src;
    @(negedge clk);
    bus2.fetch_start = 1'b0; bus2.pc_write = 1'b0;
    if (fs) repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit          fs;
    bit          pw;
    logic [1:0]  src;
    logic [31:0] off;
    logic [31:0] pc;
    logic [31:0] ir;
    bit          v;
    logic [31:0] pp4;
    bit          f;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'hA5A5_0000;
    mem[19] = 32'h1357_9BDF;
    mem[25] = 32'h0022_1820;
    mem[26] = 32'h0123_2022;
    mem[28] = 32'h0000_ABCD;
    noise = 32'd0;
    bus.fetch_start = 0; bus.pc_write = 0; bus.pc_src = 0; bus.branch_offset = 0;
    bus2.fetch_start = 0; bus2.pc_write = 0; bus2.pc_src = 0; bus2.branch_offset = 0;

    //            fs pw src  off            pc       ir            v  pp4     f
    vecs[0] = '{1, 0, 2'd0, 32'd0,          32'd100, 32'h0022_1820, 1, 32'd104, 0};
    vecs[1] = '{0, 1, 2'd0, 32'd0,          32'd104, 32'h0022_1820, 0, 32'd104, 0};
    vecs[2] = '{1, 0, 2'd0, 32'd0,          32'd104, 32'h0123_2022, 1, 32'd108, 0};
    vecs[3] = '{1, 1, 2'd1, 32'hFFFF_FFFE,  32'd100, 32'h0022_1820, 1, 32'd104, 0};
    vecs[4] = '{0, 1, 2'd3, 32'd0,          32'd100, 32'h0022_1820, 0, 32'd104, 0};
    vecs[5] = '{0, 1, 2'd1, 32'd38,         32'd256, 32'h0022_1820, 0, 32'd104, 0};
`ifdef IFU_RANGE_CHECK_EN
    vecs[6] = '{1, 0, 2'd0, 32'd0,          32'd256, NOP1,          1, 32'd260, 1};
    vecs[7] = '{0, 1, 2'd0, 32'd0,          32'd260, NOP1,          0, 32'd260, 1};
`else
    vecs[6] = '{1, 0, 2'd0, 32'd0,          32'd256, 32'hA5A5_0000, 1, 32'd260, 0};
    vecs[7] = '{0, 1, 2'd0, 32'd0,          32'd260, 32'hA5A5_0000, 0, 32'd260, 0};
`endif

    // Reset state of both instances.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst.pc",       bus.pc_out,         32'd100);
    chk("rst.ir",       bus.ir,             32'd0);
    chk("rst.ir_valid", 32'(bus.ir_valid),  32'd0);
    chk("rst.pc_plus4", bus.pc_plus4,       32'd0);
    chk("rst.busy",     32'(bus.busy),      32'd0);
    chk("rst.fault",    32'(bus.fault),     32'd0);
    chk("rst2.pc",      bus2.pc_out,        32'd102);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].fs, vecs[i].pw, vecs[i].src, vecs[i].off, bit'(i % 2));
      chk($sformatf("vec%0d.pc", i),       bus.pc_out,        vecs[i].pc);
      chk($sformatf("vec%0d.ir", i),       bus.ir,            vecs[i].ir);
      chk($sformatf("vec%0d.ir_valid", i), 32'(bus.ir_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d.pc_plus4", i), bus.pc_plus4,      vecs[i].pp4);
      chk($sformatf("vec%0d.fault", i),    32'(bus.fault),    32'(vecs[i].f));
    end

    // Misaligned fetch on the second instance; fault must stay sticky.
    op2(1, 0, 2'd0);
    chk("mis.ir",       bus2.ir,            NOP2);
    chk("mis.ir_valid", 32'(bus2.ir_valid), 32'd1);
    chk("mis.fault",    32'(bus2.fault),    32'd1);
    chk("mis.pc_plus4", bus2.pc_plus4,      32'd106);
    op2(0, 1, 2'd2);                        // jump to {0, 26'h13, 2'b00} = 76
    chk("mis.jump_pc",  bus2.pc_out,        32'd76);
    op2(1, 0, 2'd0);
    chk("mis.good_ir",  bus2.ir,            32'h1357_9BDF);
    chk("mis.sticky",   32'(bus2.fault),    32'd1);

    // Reset while in ADDR discards the fetch.
    @(negedge clk);
    bus.fetch_start = 1'b1;
    @(negedge clk);
    bus.fetch_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst.pc",       bus.pc_out,        32'd100);
    chk("midrst.busy",     32'(bus.busy),     32'd0);
    chk("midrst.ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("midrst.ir",       bus.ir,            32'd0);
    chk("midrst.fault2",   32'(bus2.fault),   32'd0);
    @(negedge clk);
    chk("midrst.stays_idle", 32'(bus.busy),   32'd0);

    // Jump: ir[25:0] = 28 with pc_plus4 = 104 gives pc = 112.
    mem[25] = 32'h0800_001C;
    run_op(1, 0, 2'd0, 32'd0, 1'b0);
    check_model("jmp_fetch");
    run_op(0, 1, 2'd2, 32'd0, 1'b0);
    chk("jmp.pc", bus.pc_out, 32'd112);
    run_op(1, 0, 2'd0, 32'd0, 1'b1);
    chk("jmp.ir", bus.ir, 32'h0000_ABCD);
    check_model("jmp_target");

    // Randomised operations against the model.
    for (int i = 0; i < 300; i++) begin
      bit          fs, pw, stray;
      logic [1:0]  src;
      logic [31:0] off;
      fs    = 1'($urandom_range(0, 1));
      pw    = 1'($urandom_range(0, 1));
      stray = 1'($urandom_range(0, 1));
      src   = 2'($urandom_range(0, 3));
      off   = 32'($urandom_range(0, 40)) - 32'd20;
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 63)] = $urandom;
      run_op(fs, pw, src, off, stray);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
